// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op codes, FSM states, condition-code bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SHL   = 4'd5,
        OP_SHR   = 4'd6,
        OP_SAR   = 4'd7,
        OP_MUL   = 4'd8,
        OP_MULHU = 4'd9,
        OP_DIVU  = 4'd10,
        OP_REMU  = 4'd11,
        OP_CMP   = 4'd12
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_C = 1;
    localparam int CC_V = 0;

    // Ops 8..11 go through the iterative datapath; op[1:0] selects which one.
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// Latency: WIDTH steps after start; done rises on the cycle whose step is the last.
// Backpressure: none; res/c are the final-step values, valid only while done.
module alu_muldiv #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             c
);
    logic [SHW-1:0]     cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;

    // Multiplier sits in acc's low half and shifts out as the product shifts in.
    assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
    assign acc_nxt = {sum, acc[WIDTH-1:1]};

    // A zero divisor always "fits", giving all-ones quotient and remainder = a.
    assign shl     = {rem, quo[WIDTH-1]};
    assign diff    = shl - {1'b0, opnd_q};
    assign ge      = ~diff[WIDTH];
    assign rem_nxt = ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], ge};

    assign done = (cnt == '0);

    always_comb begin
        res = '0;
        c   = 1'b0;
        case (op_q)
            2'b00: begin
                res = acc_nxt[WIDTH-1:0];
                c   = |acc_nxt[2*WIDTH-1:WIDTH];
            end
            2'b01: res = acc_nxt[2*WIDTH-1:WIDTH];
            2'b10: begin
                res = quo_nxt;
                c   = (opnd_q == '0);
            end
            default: begin
                res = rem_nxt;
                c   = (opnd_q == '0);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= '0;
            opnd_q <= '0;
            acc    <= '0;
            rem    <= '0;
            quo    <= '0;
        end else if (start) begin
            cnt    <= SHW'(WIDTH - 1);
            op_q   <= op;
            opnd_q <= op[1] ? b : a;
            acc    <= {{WIDTH{1'b0}}, b};
            rem    <= '0;
            quo    <= a;
        end else begin
            if (cnt != '0)
                cnt <= cnt - 1'b1;
            acc <= acc_nxt;
            rem <= rem_nxt;
            quo <= quo_nxt;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result/flags and valid/ready on both sides.
// Latency: 1 cycle for simple ops, WIDTH+1 for mul/div/rem.
// Backpressure: result held while out_valid && !out_ready; in_ready drops while busy or stalled.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       cc
);
    state_t state, state_nxt;
    logic   accept;
    logic   md_start, md_done, md_c;
    logic   load, use_md;
    logic [WIDTH-1:0] md_res;

    logic [WIDTH-1:0] s_res;
    logic             s_c, s_v;
    logic [WIDTH:0]   add_s, sub_d, shl_t, shr_t, sar_t;
    logic [SHW-1:0]   sh;
    logic             big;

    logic [WIDTH-1:0] ld_res;
    logic             ld_c, ld_v;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    alu_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .op    (op[1:0]),
        .a     (a),
        .b     (b),
        .done  (md_done),
        .res   (md_res),
        .c     (md_c)
    );

    // Extra bit on each shift carries the last bit shifted out.
    assign big   = (b >= WIDTH'(WIDTH));
    assign sh    = b[SHW-1:0];
    assign add_s = {1'b0, a} + {1'b0, b};
    assign sub_d = {1'b0, a} - {1'b0, b};
    assign shl_t = {1'b0, a} << sh;
    assign shr_t = {a, 1'b0} >> sh;
    assign sar_t = $signed({a, 1'b0}) >>> sh;

    always_comb begin
        s_res = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                s_res = add_s[WIDTH-1:0];
                s_c   = add_s[WIDTH];
                s_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                s_res = (op_t'(op) == OP_CMP) ? a : sub_d[WIDTH-1:0];
                s_c   = ~sub_d[WIDTH];
                s_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_d[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: s_res = a & b;
            OP_OR:  s_res = a | b;
            OP_XOR: s_res = a ^ b;
            OP_SHL: begin
                s_res = big ? '0 : shl_t[WIDTH-1:0];
                s_c   = big ? 1'b0 : shl_t[WIDTH];
            end
            OP_SHR: begin
                s_res = big ? '0 : shr_t[WIDTH:1];
                s_c   = big ? 1'b0 : shr_t[0];
            end
            OP_SAR: begin
                s_res = big ? {WIDTH{a[WIDTH-1]}} : sar_t[WIDTH:1];
                s_c   = big ? a[WIDTH-1] : sar_t[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        md_start  = 1'b0;
        load      = 1'b0;
        use_md    = 1'b0;
        if (accept) begin
            if (is_muldiv(op)) begin
                state_nxt = BUSY;
                md_start  = 1'b1;
            end else begin
                state_nxt = DONE;
                load      = 1'b1;
            end
        end else begin
            case (state)
                BUSY: if (md_done) begin
                    state_nxt = DONE;
                    load      = 1'b1;
                    use_md    = 1'b1;
                end
                DONE: if (out_ready) state_nxt = IDLE;
                default: ;
            endcase
        end
    end

    assign ld_res = use_md ? md_res : s_res;
    assign ld_c   = use_md ? md_c : s_c;
    assign ld_v   = use_md ? 1'b0 : s_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            cc     <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                result   <= ld_res;
                cc[CC_N] <= ld_res[WIDTH-1];
                cc[CC_Z] <= (ld_res == '0);
                cc[CC_C] <= ld_c;
                cc[CC_V] <= ld_v;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=16 with hand-computed results, flags and latencies.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  cc;

    int checks   = 0;
    int failures = 0;

    alu_mc #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cc        (cc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one op with out_ready=1; lat counts negedges from accept to out_valid.
    task automatic run_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                          output int lat, output int stall,
                          output logic [15:0] r, output logic [3:0] f);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
        lat = 0; stall = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!in_ready) stall++;
        end while (!out_valid && lat < 40);
        r = result;
        f = cc;
    endtask

    typedef struct {
        string       name;
        logic [3:0]  o;
        logic [15:0] x, y;
        logic [15:0] er;
        logic [3:0]  ecc;
        int          elat;
    } vec_t;

    vec_t vecs[] = '{
        '{"add_ovf",  4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1},
        '{"sub_eq",   4'd1,  16'h0005, 16'h0005, 16'h0000, 4'b0110, 1},
        '{"sub_brw",  4'd1,  16'h0000, 16'h0001, 16'hFFFF, 4'b1000, 1},
        '{"and",      4'd2,  16'hF0F0, 16'hFF00, 16'hF000, 4'b1000, 1},
        '{"or",       4'd3,  16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000, 1},
        '{"mul",      4'd8,  16'h0123, 16'h0100, 16'h2300, 4'b0010, 17},
        '{"mulhu",    4'd9,  16'h0123, 16'h0100, 16'h0001, 4'b0000, 17},
        '{"divu",     4'd10, 16'd100,  16'd7,    16'h000E, 4'b0000, 17},
        '{"remu",     4'd11, 16'd100,  16'd7,    16'h0002, 4'b0000, 17},
        '{"divu_z",   4'd10, 16'd5,    16'd0,    16'hFFFF, 4'b1010, 17},
        '{"remu_z",   4'd11, 16'd5,    16'd0,    16'h0005, 4'b0010, 17},
        '{"sar_big",  4'd7,  16'h8000, 16'd20,   16'hFFFF, 4'b1010, 1},
        '{"sar_3",    4'd7,  16'h8004, 16'd3,    16'hF000, 4'b1010, 1},
        '{"shr_16",   4'd6,  16'h8001, 16'd16,   16'h0000, 4'b0100, 1},
        '{"shr_1",    4'd6,  16'h8001, 16'd1,    16'h4000, 4'b0010, 1},
        '{"shl_1",    4'd5,  16'h8001, 16'd1,    16'h0002, 4'b0010, 1},
        '{"shl_0",    4'd5,  16'h1234, 16'd0,    16'h1234, 4'b0000, 1},
        '{"cmp",      4'd12, 16'h8000, 16'h0001, 16'h8000, 4'b1011, 1},
        '{"rsvd",     4'd13, 16'h1234, 16'h5678, 16'h0000, 4'b0100, 1}
    };

    initial begin
        int          lat, stall, seen;
        logic [15:0] r;
        logic [3:0]  f;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_result",    result,    0);
        chk("rst_cc",        cc,        0);

        foreach (vecs[i]) begin
            run_op(vecs[i].o, vecs[i].x, vecs[i].y, lat, stall, r, f);
            chk({vecs[i].name, "_res"}, r,   vecs[i].er);
            chk({vecs[i].name, "_cc"},  f,   vecs[i].ecc);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].elat);
            if (vecs[i].elat > 1)
                chk({vecs[i].name, "_busy"}, stall, 16);
        end

        // Backpressure: hold ADD result for 3 cycles, then chain XOR with no bubble.
        @(negedge clk);
        op = 4'd0; a = 16'd2; b = 16'd3; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_res",   result,    16'h0005);
            chk("bp_rdy",   in_ready,  0);
        end
        op = 4'd4; a = 16'h00FF; b = 16'h0F0F; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("bp_rdy_release", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("chain_valid", out_valid, 1);
        chk("chain_res",   result,    16'h0FF0);
        chk("chain_cc",    cc,        4'b0000);

        // Reset during BUSY discards the divide.
        @(negedge clk);
        op = 4'd10; a = 16'd100; b = 16'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("busy_before_rst", in_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_rdy",   in_ready,  1);
        chk("mrst_cc",    cc,        0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mrst_no_result", seen, 0);
        run_op(4'd0, 16'd1, 16'd1, lat, stall, r, f);
        chk("post_rst_res", r,   16'h0002);
        chk("post_rst_lat", lat, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU and successor to the single-cycle combinational ALU used by the CPU execute stage.
- Adds registered results and a valid/ready handshake on both the operand and result sides.
- Adds iterative multiply, divide and remainder operations.
- Produces corrected N/Z/C/V condition codes for any WIDTH.

Parameters:
- WIDTH, 16: operand and result width in bits; minimum 4.
- SHW, $clog2(WIDTH): width of the iteration counter; internal use, not overridden.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: op, a and b are valid.
- in_ready, output, 1: unit can accept an operation this cycle.
- op, input, 4: operation code; see Behaviour.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- out_valid, output, 1: result and cc are valid.
- out_ready, input, 1: consumer accepts the result.
- result, output, WIDTH: registered result.
- cc, output, 4: registered flags {N,Z,C,V} = cc[3:0].

Behaviour:
- Reset: state=IDLE, out_valid=0, result=0, cc=0, in_ready=1 in the cycle after rst. rst wins over every other event. A reset during BUSY discards the operation; no out_valid is produced for it.
- Accept: an operation is accepted on a cycle where in_valid && in_ready. Operands are captured on that cycle. Operand changes after acceptance have no effect.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back operation with no bubble.
- Result hold: result, cc and out_valid stay stable while out_valid && !out_ready.
- States and transitions:
  - IDLE, op accepted:
    - simple op -> DONE, result loaded at the next edge.
    - op 8-11 -> BUSY, cnt=WIDTH-1.
  - BUSY: cnt decrements each cycle; at cnt==0 go to DONE with the result loaded.
  - DONE, out_ready:
    - new accept -> same as the IDLE accept rules.
    - no accept -> IDLE.
- Latency, with acceptance at edge T:
  - simple ops: out_valid at T+1.
  - op 8-11: out_valid at T+WIDTH+1.
  - Throughput for simple ops is 1 per cycle.
- Op codes and flags. Default is C=0 and V=0 unless stated.
  - 0 ADD: a+b. C = carry out. V = signed overflow.
  - 1 SUB: a-b. C = 1 when no borrow (a>=b unsigned). V = signed overflow.
  - 2 AND: a&b.
  - 3 OR: a|b.
  - 4 XOR: a^b.
  - 5 SHL: a << b.
  - 6 SHR: logical a >> b.
  - 7 SAR: arithmetic a >>> b.
  - 8 MUL: low WIDTH bits of the unsigned a*b. C=1 when the high half is nonzero.
  - 9 MULHU: high WIDTH bits of the unsigned a*b.
  - 10 DIVU: unsigned a/b.
  - 11 REMU: unsigned a%b.
  - 12 CMP: same as SUB for flags, but result = a (pass-through).
  - 13-15: reserved. Result 0, cc = {0,1,0,0}, latency 1.
- Shifts:
  - The amount is the full unsigned b.
  - b >= WIDTH gives 0 for SHL and SHR, and WIDTH copies of a[WIDTH-1] for SAR.
  - C = last bit shifted out. C=0 when b==0. For b >= WIDTH: C=0 for SHL/SHR, C=a[WIDTH-1] for SAR.
- Divide by zero:
  - DIVU gives all-ones; REMU gives a; C=1 in both cases.
  - Latency is unchanged (still WIDTH cycles).
  - For a valid divide, C=0.
- All ops: N = result[WIDTH-1]; Z = (result == 0) at full WIDTH.
- Multiply: shift-add, one bit of b per cycle, 2*WIDTH accumulator.
- Divide: restoring, one quotient bit per cycle.

Decomposition:
- Package alu_pkg:
  - op_t enum: OP_ADD..OP_CMP, 4 bits.
  - cc bit index constants CC_N=3, CC_Z=2, CC_C=1, CC_V=0.
  - state_t enum {IDLE, BUSY, DONE}.
- Sub-module alu_muldiv(WIDTH):
  - Iterative multiply/divide datapath with start, op[1:0] and done.
  - Owns the accumulator, remainder and quotient registers.
  - alu_mc owns the handshake, the FSM, the simple ops and flag generation.

Test Plan (WIDTH=16):
- ADD a=0x7FFF b=0x0001, out_ready=1 -> out_valid at T+1, result=0x8000, cc N=1 Z=0 C=0 V=1. SUB 5-5 -> 0x0000, cc Z=1 C=1 V=0. SUB 0-1 -> 0xFFFF, N=1 C=0.
- MUL a=0x0123 b=0x0100 -> in_ready=0 for cycles T+1..T+16, out_valid at T+17, result=0x2300, C=1. MULHU with the same operands -> 0x0001.
- DIVU 100/7 -> 0x000E, C=0. REMU 100/7 -> 0x0002. DIVU 5/0 -> 0xFFFF, C=1, at T+17. REMU 5/0 -> 0x0005, C=1.
- SAR 0x8000 by 20 -> 0xFFFF, N=1, C=1. SHR 0x8001 by 16 -> 0x0000, Z=1, C=0. SHL 0x8001 by 1 -> 0x0002, C=1. SHL by 0 -> a unchanged, C=0.
- Backpressure: ADD 2+3 with out_ready=0 for 3 cycles -> result=0x0005 stable, in_ready=0. Raise out_ready together with in_valid on a new XOR -> new result the next cycle, with no bubble between the two out_valid pulses.
- Reset mid-op: start DIVU, assert rst at BUSY cycle 5 -> next cycle out_valid=0, in_ready=1, cc=0. A following ADD 1+1 returns 0x0002 at T+1.
